// File: rtl/mem_arb_if.sv
// Handshake bundle between the I/D cache miss paths, the shared memory port and mem_arb.
// The slave modport is the arbiter's view; master is the surrounding caches plus memory.
interface mem_arb_if;
    logic        i_req;
    logic [15:0] i_addr;
    logic        i_done;
    logic [15:0] i_rdata;
    logic        d_req;
    logic        d_wr;
    logic [15:0] d_addr;
    logic [15:0] d_wdata;
    logic        d_done;
    logic [15:0] d_rdata;
    logic        mem_rd;
    logic        mem_wr;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_done;
    logic        busy;

    modport slave (
        input  i_req, i_addr, d_req, d_wr, d_addr, d_wdata, mem_rdata, mem_done,
        output i_done, i_rdata, d_done, d_rdata, mem_rd, mem_wr, mem_addr, mem_wdata, busy
    );

    modport master (
        output i_req, i_addr, d_req, d_wr, d_addr, d_wdata, mem_rdata, mem_done,
        input  i_done, i_rdata, d_done, d_rdata, mem_rd, mem_wr, mem_addr, mem_wdata, busy
    );
endinterface

// File: rtl/mem_arb.sv
// Arbitrates the I- and D-cache miss paths onto one memory port, one transaction at a time.
// D has priority; a saturating streak counter forces an I grant after MAX_D_STREAK D wins.
module mem_arb #(
    parameter int unsigned MAX_D_STREAK = 4
) (
    input logic      clk,
    input logic      rst,
    mem_arb_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [2:0] STREAK_MAX = 3'(MAX_D_STREAK);

    state_t      state_q,     state_d;
    logic [2:0]  streak_q,    streak_d;
    logic        win_is_d_q,  win_is_d_d;
    logic        mem_rd_q,    mem_rd_d;
    logic        mem_wr_q,    mem_wr_d;
    logic [15:0] mem_addr_q,  mem_addr_d;
    logic [15:0] mem_wdata_q, mem_wdata_d;
    logic        i_done_q,    i_done_d;
    logic        d_done_q,    d_done_d;
    logic [15:0] i_rdata_q,   i_rdata_d;
    logic [15:0] d_rdata_q,   d_rdata_d;
    logic        busy_q,      busy_d;
    logic        d_wins_s;

    // Next-state, grant and output-register computation
    always_comb begin
        state_d     = state_q;
        streak_d    = streak_q;
        win_is_d_d  = win_is_d_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        i_rdata_d   = i_rdata_q;
        d_rdata_d   = d_rdata_q;
        mem_rd_d    = 1'b0;
        mem_wr_d    = 1'b0;
        i_done_d    = 1'b0;
        d_done_d    = 1'b0;
        d_wins_s    = bus.d_req && !(bus.i_req && (streak_q == STREAK_MAX));

        case (state_q)
            S_IDLE: begin
                if (d_wins_s) begin
                    state_d     = S_ISSUE;
                    win_is_d_d  = 1'b1;
                    mem_addr_d  = bus.d_addr;
                    mem_wdata_d = bus.d_wdata;
                    mem_rd_d    = !bus.d_wr;
                    mem_wr_d    = bus.d_wr;
                    if (!bus.i_req) begin
                        streak_d = 3'd0;
                    end else if (streak_q < STREAK_MAX) begin
                        streak_d = streak_q + 3'd1;
                    end else begin
                        streak_d = streak_q;
                    end
                end else if (bus.i_req) begin
                    state_d     = S_ISSUE;
                    win_is_d_d  = 1'b0;
                    mem_addr_d  = bus.i_addr;
                    mem_wdata_d = 16'h0000;
                    mem_rd_d    = 1'b1;
                    streak_d    = 3'd0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (bus.mem_done) begin
                    state_d = S_DONE;
                    if (win_is_d_q) begin
                        d_rdata_d = bus.mem_rdata;
                        d_done_d  = 1'b1;
                    end else begin
                        i_rdata_d = bus.mem_rdata;
                        i_done_d  = 1'b1;
                    end
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // State and output registers; reset abandons any transaction in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            streak_q    <= 3'd0;
            win_is_d_q  <= 1'b0;
            mem_rd_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
            mem_addr_q  <= 16'h0000;
            mem_wdata_q <= 16'h0000;
            i_done_q    <= 1'b0;
            d_done_q    <= 1'b0;
            i_rdata_q   <= 16'h0000;
            d_rdata_q   <= 16'h0000;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            streak_q    <= streak_d;
            win_is_d_q  <= win_is_d_d;
            mem_rd_q    <= mem_rd_d;
            mem_wr_q    <= mem_wr_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            i_done_q    <= i_done_d;
            d_done_q    <= d_done_d;
            i_rdata_q   <= i_rdata_d;
            d_rdata_q   <= d_rdata_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.mem_rd    = mem_rd_q;
    assign bus.mem_wr    = mem_wr_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.i_done    = i_done_q;
    assign bus.d_done    = d_done_q;
    assign bus.i_rdata   = i_rdata_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.busy      = busy_q;
endmodule

// File: doc/mem_arb.md
Name: mem_arb

Overview:
- Arbiter and sequencer between the instruction-cache and data-cache miss paths and the single shared main-memory port.
- Accepts at most one outstanding memory transaction at a time.
- Data-side requests have priority; a streak counter guarantees forward progress for instruction fetch.
- Sits between the cache controllers and the memory in the memory-system top level, below the pipeline's fetch and memory stages.

Parameters:
- MAX_D_STREAK, 4: number of consecutive D grants allowed while i_req is pending before I is forced to win; legal range 1..7.

Ports:
- clk  in  1  system clock
- rst  in  1  reset (see Behaviour)
- i_req  in  1  I-cache read request; level, held until i_done
- i_addr  in  16  I-cache request address
- i_done  out  1  one-cycle pulse; i_rdata valid
- i_rdata  out  16  read data for I
- d_req  in  1  D-cache request; level, held until d_done
- d_wr  in  1  1 = write, 0 = read
- d_addr  in  16  D-cache request address
- d_wdata  in  16  D write data
- d_done  out  1  one-cycle pulse; d_rdata valid (reads) or write complete
- d_rdata  out  16  read data for D
- mem_rd  out  1  one-cycle memory read strobe
- mem_wr  out  1  one-cycle memory write strobe
- mem_addr  out  16  memory address
- mem_wdata  out  16  memory write data
- mem_rdata  in  16  memory read data; valid with mem_done
- mem_done  in  1  memory completion pulse
- busy  out  1  1 whenever state != IDLE

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous, active-high.
- Reset values: every output 0, state IDLE, streak counter 0.
  - i_rdata/d_rdata hold their last value until the next done pulse; their reset value is 0.
- States:
  - IDLE:
    - If neither request is pending, stay in IDLE.
    - Otherwise pick a winner: D wins unless (i_req && streak == MAX_D_STREAK).
    - Latch winner id, address, wr flag and wdata into registers; go to ISSUE.
  - ISSUE:
    - Assert mem_rd or mem_wr for exactly this one cycle; mem_addr/mem_wdata come from the latched values.
    - mem_done is ignored in this state. Go to WAIT.
  - WAIT:
    - mem_addr/mem_wdata stay held; strobes are 0.
    - On mem_done, capture mem_rdata into the winner's rdata register; go to DONE.
  - DONE:
    - Assert the winner's done for one cycle; go to IDLE.
- Minimum latency: request sampled in IDLE at cycle T -> strobe at T+1 -> mem_done no earlier than T+2 -> done at (mem_done cycle)+1.
- Requesters drop req on the edge at which they see done. Because IDLE samples req only after DONE, the same request is never re-granted.
- Streak counter (3 bits, saturating at MAX_D_STREAK):
  - D granted with i_req=1: increment.
  - D granted with i_req=0: clear.
  - I granted: clear.
- Request changes: changes to addr/wdata/wr after the grant are ignored, since the values are latched. A req deasserted before its grant is simply not served.
- mem_done outside WAIT (IDLE, ISSUE, DONE) is ignored: no done pulse, no rdata update.
- d_rdata is updated on D writes too, with whatever mem_rdata carries; requesters ignore it.
- Reset asserted in any state: next cycle IDLE, all strobes and dones 0, transaction abandoned. A late mem_done after reset produces no done pulse.
- Simultaneous i_req and d_req with streak < MAX_D_STREAK: D wins. I waits in IDLE-pending until the D transaction completes.

Test Plan:
- I-only read: i_req=1, i_addr=0x0040 at cycle 0; memory returns 0xBEEF with mem_done at cycle 4 -> mem_rd=1 with mem_addr=0x0040 at cycle 1 only; i_done=1, i_rdata=0xBEEF at cycle 5; busy 1 from cycle 1 to cycle 5.
- Simultaneous requests: i_req and d_req (read 0x0100) raised in the same cycle -> D strobe first; I strobe issued in the cycle after d_done's IDLE sample; streak=1 after the D grant.
- Starvation: d_req and i_req held continuously, MAX_D_STREAK=4, 1-cycle memory -> grant order D,D,D,D,I,D,D,D,D,I.
- D write: d_req=1, d_wr=1, d_addr=0x2000, d_wdata=0x1234 -> mem_wr=1 for one cycle with mem_addr=0x2000, mem_wdata=0x1234; mem_rd=0; d_done pulses one cycle after mem_done.
- Reset mid-op: rst=1 for one cycle while in WAIT -> all outputs 0 and busy=0 the next cycle; a subsequent mem_done yields no i_done/d_done.
- Spurious completion: mem_done pulsed in IDLE and in ISSUE -> no done pulse, rdata registers unchanged, state unaffected.
